// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one SRAM-like request/response port between the
// instruction-fetch side (i_*) and the load/store side (d_*). Requests are
// granted with fixed data priority and held through the address handshake.
// Accepted requests are recorded in a small in-order ID FIFO so that each
// m_data_ok is steered back to the requester that issued it.
module mem_port_arbiter #(
    parameter int XLEN            = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic              clk,
    input  logic              rst,
    // fetch requester
    input  logic              i_req,
    input  logic              i_write,
    input  logic [XLEN/8-1:0] i_wstrb,
    input  logic [XLEN-1:0]   i_addr,
    input  logic [XLEN-1:0]   i_wdata,
    output logic              i_addr_ok,
    output logic              i_data_ok,
    output logic [XLEN-1:0]   i_rdata,
    // load/store requester
    input  logic              d_req,
    input  logic              d_write,
    input  logic [XLEN/8-1:0] d_wstrb,
    input  logic [XLEN-1:0]   d_addr,
    input  logic [XLEN-1:0]   d_wdata,
    output logic              d_addr_ok,
    output logic              d_data_ok,
    output logic [XLEN-1:0]   d_rdata,
    // shared memory port
    output logic              m_req,
    output logic              m_write,
    output logic [XLEN/8-1:0] m_wstrb,
    output logic [XLEN-1:0]   m_addr,
    output logic [XLEN-1:0]   m_wdata,
    input  logic              m_addr_ok,
    input  logic              m_data_ok,
    input  logic [XLEN-1:0]   m_rdata,
    // sticky protocol error
    output logic              err_unexp_rsp
);

    localparam int SW    = XLEN / 8;
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W = PTR_W + 1;

    // requester IDs as stored in the FIFO
    localparam logic ID_I = 1'b0;
    localparam logic ID_D = 1'b1;

    typedef struct packed {
        logic            write;
        logic [SW-1:0]   wstrb;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
    } req_t;

    req_t i_pl;
    req_t d_pl;
    req_t m_pl;

    // grant / lock state
    logic lock_q, lock_d;
    logic lock_id_q, lock_id_d;
    logic gnt_vld;
    logic gnt_id;
    logic gnt_req;
    logic fire;

    // ID FIFO state
    logic [MAX_OUTSTANDING-1:0] fifo_q, fifo_d;
    logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]           count_q, count_d;
    logic                       full;
    logic                       empty;
    logic                       push;
    logic                       pop;
    logic                       head_id;

    logic err_q, err_d;

    assign i_pl = '{write: i_write, wstrb: i_wstrb, addr: i_addr, wdata: i_wdata};
    assign d_pl = '{write: d_write, wstrb: d_wstrb, addr: d_addr, wdata: d_wdata};

    assign full  = (count_q == CNT_W'(MAX_OUTSTANDING));
    assign empty = (count_q == '0);

    // Grant selection: a locked grant is kept until its handshake completes,
    // otherwise data side wins. Reset forces no grant so every output is 0.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = ID_I;
        if (rst) begin
            gnt_vld = 1'b0;
        end else if (lock_q) begin
            gnt_vld = 1'b1;
            gnt_id  = lock_id_q;
        end else if (d_req) begin
            gnt_vld = 1'b1;
            gnt_id  = ID_D;
        end else if (i_req) begin
            gnt_vld = 1'b1;
            gnt_id  = ID_I;
        end
    end

    assign gnt_req = (gnt_id == ID_D) ? d_req : i_req;

    // Full is the registered count: a pop in the same cycle does not free a
    // slot for a push until the next cycle.
    assign m_req = gnt_vld & gnt_req & ~full;
    assign m_pl  = gnt_vld ? ((gnt_id == ID_D) ? d_pl : i_pl) : '0;

    assign m_write = m_pl.write;
    assign m_wstrb = m_pl.wstrb;
    assign m_addr  = m_pl.addr;
    assign m_wdata = m_pl.wdata;

    assign fire      = m_req & m_addr_ok;
    assign i_addr_ok = fire & (gnt_id == ID_I);
    assign d_addr_ok = fire & (gnt_id == ID_D);

    // Response steering: data_ok goes to the requester at the FIFO head,
    // rdata is broadcast to both sides.
    assign push      = fire;
    assign pop       = m_data_ok & ~empty & ~rst;
    assign head_id   = fifo_q[rd_ptr_q];
    assign i_data_ok = pop & (head_id == ID_I);
    assign d_data_ok = pop & (head_id == ID_D);
    assign i_rdata   = rst ? '0 : m_rdata;
    assign d_rdata   = rst ? '0 : m_rdata;

    assign err_unexp_rsp = err_q;

    // Lock next-state: hold the current grant while the memory stalls accept.
    always_comb begin
        lock_d    = lock_q;
        lock_id_d = lock_id_q;
        if (fire) begin
            lock_d = 1'b0;
        end else if (m_req) begin
            lock_d    = 1'b1;
            lock_id_d = gnt_id;
        end
    end

    // FIFO next-state: write ID at tail on accept, advance head on response.
    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            fifo_d[wr_ptr_q] = gnt_id;
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Error next-state: any response with nothing outstanding is sticky.
    always_comb begin
        err_d = err_q | (m_data_ok & empty);
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_q    <= 1'b0;
            lock_id_q <= ID_I;
            fifo_q    <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            lock_q    <= lock_d;
            lock_id_q <= lock_id_d;
            fifo_q    <= fifo_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            err_q     <= err_d;
        end
    end

endmodule
